// File: rtl/layer_compositor.sv
// layer_compositor: picks the highest-priority enabled sprite layer colour
// (lowest index wins), falls back to a background colour, blanks outside the
// visible area and optionally replaces the scene with a flashing full-screen
// game-over / win overlay. Two register stages from inputs to vga_rgb.
module layer_compositor #(
   parameter int                 N_LAYERS     = 11,
   parameter int                 COLOR_W      = 12,
   parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h69C,
   parameter logic [COLOR_W-1:0] LOSE_COLOR   = 12'hF00,
   parameter logic [COLOR_W-1:0] WIN_COLOR    = 12'h0F0,
   parameter int                 FLASH_FRAMES = 30
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          bright,
   input  logic                          frame_start,
   input  logic [N_LAYERS-1:0]           layer_en,
   input  logic [N_LAYERS*COLOR_W-1:0]   layer_rgb,
   input  logic                          lose_evt,
   input  logic                          win_evt,
   input  logic                          restart,
   output logic [COLOR_W-1:0]            vga_rgb,
   output logic                          hit_valid,
   output logic [$clog2(N_LAYERS)-1:0]   hit_layer,
   output logic [1:0]                    game_state
);

   localparam int IDX_W  = $clog2(N_LAYERS);
   localparam int CNT_W  = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
   localparam int LAST_I = (FLASH_FRAMES > 0) ? FLASH_FRAMES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

   typedef enum logic [1:0] {
      PLAY = 2'b00,
      LOSE = 2'b01,
      WIN  = 2'b10
   } state_t;

   logic                enc_hit;
   logic [IDX_W-1:0]    enc_idx;
   logic [COLOR_W-1:0]  enc_rgb;

   logic                s1_hit;
   logic [IDX_W-1:0]    s1_idx;
   logic [COLOR_W-1:0]  s1_rgb;
   logic                s1_bright;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                phase_q, phase_d;

   // Priority encoder: scan from the top so the lowest enabled index is written last and wins.
   always_comb begin
      enc_hit = 1'b0;
      enc_idx = '0;
      enc_rgb = BG_COLOR;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (layer_en[i]) begin
            enc_hit = 1'b1;
            enc_idx = IDX_W'(i);
            enc_rgb = layer_rgb[i*COLOR_W +: COLOR_W];
         end
      end
   end

   // Stage 1: capture the selected scene colour together with its hit info and blanking flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_hit    <= 1'b0;
         s1_idx    <= '0;
         s1_rgb    <= '0;
         s1_bright <= 1'b0;
      end else begin
         s1_hit    <= enc_hit;
         s1_idx    <= enc_idx;
         s1_rgb    <= enc_rgb;
         s1_bright <= bright;
      end
   end

   // Game-state transitions and overlay flash timing; entering LOSE/WIN clears the counter even if frame_start is high.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      case (state_q)
         PLAY: begin
            cnt_d   = '0;
            phase_d = 1'b0;
            if (lose_evt) begin
               state_d = LOSE;
               phase_d = 1'b1;
            end else if (win_evt) begin
               state_d = WIN;
               phase_d = 1'b1;
            end
         end
         LOSE, WIN: begin
            if (restart) begin
               state_d = PLAY;
               cnt_d   = '0;
               phase_d = 1'b0;
            end else if (FLASH_FRAMES == 0) begin
               cnt_d   = '0;
               phase_d = 1'b1;
            end else if (frame_start) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  phase_d = ~phase_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = PLAY;
            cnt_d   = '0;
            phase_d = 1'b0;
         end
      endcase
   end

   // Game-state, frame counter and overlay phase registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= PLAY;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // Stage 2: blank, overlay or pass the scene; hit info follows the pixel regardless of blanking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_rgb   <= '0;
         hit_valid <= 1'b0;
         hit_layer <= '0;
      end else begin
         if (!s1_bright) begin
            vga_rgb <= '0;
         end else if ((state_q != PLAY) && phase_q) begin
            vga_rgb <= (state_q == LOSE) ? LOSE_COLOR : WIN_COLOR;
         end else begin
            vga_rgb <= s1_rgb;
         end
         hit_valid <= s1_hit;
         hit_layer <= s1_idx;
      end
   end

   assign game_state = state_q;

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: drives three compositor configurations (default,
// FLASH_FRAMES=2, and 32 layers x 24-bit colour) from shared controls and
// compares every cycle against a pixel/frame-level model, plus directed
// vector tables and hand-written FSM / flash sequences.
module tb_layer_compositor;

   logic          clk = 1'b0;
   logic          reset;
   logic          bright;
   logic          frame_start;
   logic [10:0]   layer_en;
   logic [131:0]  layer_rgb;
   logic          lose_evt;
   logic          win_evt;
   logic          restart;
   logic [31:0]   layer_en32;
   logic [767:0]  layer_rgb32;

   logic [11:0]   vga0, vga1;
   logic [23:0]   vga2;
   logic          hv0, hv1, hv2;
   logic [3:0]    hl0, hl1;
   logic [4:0]    hl2;
   logic [1:0]    gs0, gs1, gs2;

   int n_checks;
   int n_errors;
   bit check_on;

   typedef struct packed {
      logic [23:0] vga;
      logic        hit;
      logic [4:0]  idx;
   } pix_t;

   typedef struct {
      logic         bright;
      logic [10:0]  en;
      logic [131:0] rgb;
      logic [11:0]  exp_vga;
      logic         exp_hit;
      logic [3:0]   exp_idx;
   } vec_t;

   vec_t   vecs [8];
   bit     flash_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [131:0] base_rgb;
   logic [131:0] tmp_rgb;

   int   m_state;
   int   m_frames;
   pix_t rec0, rec1, rec2;
   pix_t exp0, exp1, exp2;

   always #5 clk = ~clk;

   layer_compositor dut0 (
      .clk(clk), .reset(reset), .bright(bright), .frame_start(frame_start),
      .layer_en(layer_en), .layer_rgb(layer_rgb), .lose_evt(lose_evt),
      .win_evt(win_evt), .restart(restart), .vga_rgb(vga0),
      .hit_valid(hv0), .hit_layer(hl0), .game_state(gs0)
   );

   layer_compositor #(.FLASH_FRAMES(2)) dut1 (
      .clk(clk), .reset(reset), .bright(bright), .frame_start(frame_start),
      .layer_en(layer_en), .layer_rgb(layer_rgb), .lose_evt(lose_evt),
      .win_evt(win_evt), .restart(restart), .vga_rgb(vga1),
      .hit_valid(hv1), .hit_layer(hl1), .game_state(gs1)
   );

   layer_compositor #(.N_LAYERS(32), .COLOR_W(24), .BG_COLOR(24'h00069C),
                      .LOSE_COLOR(24'h000F00), .WIN_COLOR(24'h0000F0)) dut2 (
      .clk(clk), .reset(reset), .bright(bright), .frame_start(frame_start),
      .layer_en(layer_en32), .layer_rgb(layer_rgb32), .lose_evt(lose_evt),
      .win_evt(win_evt), .restart(restart), .vga_rgb(vga2),
      .hit_valid(hv2), .hit_layer(hl2), .game_state(gs2)
   );

   // Game state: 0 play, 1 lose, 2 win.
   function automatic int next_state(int st, logic lose, logic win, logic rs);
      if (st == 0) return lose ? 1 : (win ? 2 : 0);
      return rs ? 0 : st;
   endfunction

   // Frames seen since entering LOSE/WIN.
   function automatic int next_frames(int st, int fr, logic rs, logic fs);
      if (st == 0 || rs) return 0;
      return fs ? fr + 1 : fr;
   endfunction

   function automatic bit phase_on(int fr, int ff);
      if (ff == 0) return 1'b1;
      return ((fr / ff) % 2) == 0;
   endfunction

   function automatic pix_t compose(logic br, logic [31:0] en, logic [767:0] rgb,
                                    int n, int cw, int st, int fr, int ff);
      pix_t         p;
      logic [767:0] mask;
      logic [23:0]  scene;
      bit           found;
      p     = '0;
      found = 1'b0;
      scene = 24'h00069C;
      mask  = (768'd1 << cw) - 768'd1;
      for (int i = 0; i < n; i++) begin
         if (en[i] && !found) begin
            found = 1'b1;
            p.hit = 1'b1;
            p.idx = 5'(i);
            scene = 24'((rgb >> (i * cw)) & mask);
         end
      end
      if (!br)
         p.vga = '0;
      else if (st != 0 && phase_on(fr, ff))
         p.vga = (st == 1) ? 24'h000F00 : 24'h0000F0;
      else
         p.vga = scene;
      return p;
   endfunction

   // Reference model: state after each edge, and the pixel each configuration shows one edge later.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state  <= 0;
         m_frames <= 0;
         rec0 <= '0; rec1 <= '0; rec2 <= '0;
         exp0 <= '0; exp1 <= '0; exp2 <= '0;
      end else begin
         exp0 <= rec0;
         exp1 <= rec1;
         exp2 <= rec2;
         m_state  <= next_state(m_state, lose_evt, win_evt, restart);
         m_frames <= next_frames(m_state, m_frames, restart, frame_start);
         rec0 <= compose(bright, {21'd0, layer_en}, {636'd0, layer_rgb}, 11, 12,
                         next_state(m_state, lose_evt, win_evt, restart),
                         next_frames(m_state, m_frames, restart, frame_start), 30);
         rec1 <= compose(bright, {21'd0, layer_en}, {636'd0, layer_rgb}, 11, 12,
                         next_state(m_state, lose_evt, win_evt, restart),
                         next_frames(m_state, m_frames, restart, frame_start), 2);
         rec2 <= compose(bright, layer_en32, layer_rgb32, 32, 24,
                         next_state(m_state, lose_evt, win_evt, restart),
                         next_frames(m_state, m_frames, restart, frame_start), 30);
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      cmp("model_vga0", 32'(vga0), 32'(exp0.vga[11:0]));
      cmp("model_hit0", 32'(hv0), 32'(exp0.hit));
      cmp("model_idx0", 32'(hl0), 32'(exp0.idx[3:0]));
      cmp("model_state0", 32'(gs0), 32'(m_state));
      cmp("model_vga1", 32'(vga1), 32'(exp1.vga[11:0]));
      cmp("model_state1", 32'(gs1), 32'(m_state));
      cmp("model_vga2", 32'(vga2), 32'(exp2.vga));
      cmp("model_hit2", 32'(hv2), 32'(exp2.hit));
      cmp("model_idx2", 32'(hl2), 32'(exp2.idx));
   endtask

   task automatic applyStimulus(input logic br, input logic [10:0] en, input logic [131:0] rgb);
      @(negedge clk);
      bright    = br;
      layer_en  = en;
      layer_rgb = rgb;
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   // Per-cycle model comparison, sampled on the inactive edge.
   always @(negedge clk) begin
      if (check_on) checkOutput();
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      check_on = 1'b0;
      reset = 1'b0;
      bright = 1'b0;
      frame_start = 1'b0;
      layer_en = '0;
      layer_rgb = '0;
      lose_evt = 1'b0;
      win_evt = 1'b0;
      restart = 1'b0;
      layer_en32 = '0;
      layer_rgb32 = '0;

      for (int i = 0; i < 11; i++) base_rgb[i*12 +: 12] = 12'hE00 | 12'(i);
      tmp_rgb = base_rgb;
      tmp_rgb[24 +: 12] = 12'h123;
      tmp_rgb[60 +: 12] = 12'h456;
      vecs[0] = '{1'b1, 11'd0,               base_rgb, 12'h69C, 1'b0, 4'd0};
      vecs[1] = '{1'b1, 11'b000_0010_0100,   tmp_rgb,  12'h123, 1'b1, 4'd2};
      vecs[2] = '{1'b0, 11'b000_0010_0100,   tmp_rgb,  12'h000, 1'b1, 4'd2};
      vecs[3] = '{1'b1, 11'b100_0000_0000,   base_rgb, 12'hE0A, 1'b1, 4'd10};
      vecs[4] = '{1'b1, 11'b111_1111_1111,   base_rgb, 12'hE00, 1'b1, 4'd0};
      vecs[5] = '{1'b0, 11'd0,               base_rgb, 12'h000, 1'b0, 4'd0};
      vecs[6] = '{1'b1, 11'b010_1000_0000,   base_rgb, 12'hE07, 1'b1, 4'd7};
      vecs[7] = '{1'b1, 11'd0,               base_rgb, 12'h69C, 1'b0, 4'd0};

      repeat (3) @(negedge clk);
      cmp("reset_vga", 32'(vga0), 32'd0);
      cmp("reset_state", 32'(gs0), 32'd0);
      reset = 1'b1;
      check_on = 1'b1;

      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].bright, vecs[v].en, vecs[v].rgb);
         @(posedge clk);
         @(posedge clk);
         #1;
         cmp($sformatf("vec%0d_vga", v), 32'(vga0), 32'(vecs[v].exp_vga));
         cmp($sformatf("vec%0d_hit", v), 32'(hv0), 32'(vecs[v].exp_hit));
         cmp($sformatf("vec%0d_idx", v), 32'(hl0), 32'(vecs[v].exp_idx));
      end

      // Mid-stream asynchronous reset, then two cycles to the first valid pixel.
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      cmp("async_reset_vga", 32'(vga0), 32'd0);
      cmp("async_reset_hit", 32'(hv0), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 cmp("post_reset_1", 32'(vga0), 32'd0);
      @(posedge clk);
      #1 cmp("post_reset_2", 32'(vga0), 32'h69C);

      // Walking one, back to back, distinct colours.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         layer_en = 11'(1 << i);
         layer_rgb[i*12 +: 12] = 12'(12'h200 + i * 17);
      end
      @(negedge clk);
      layer_en = '0;
      repeat (3) @(negedge clk);

      // Simultaneous lose/win: LOSE wins and is sticky.
      lose_evt = 1'b1;
      win_evt  = 1'b1;
      @(negedge clk);
      cmp("lose_priority", 32'(gs0), 32'd1);
      lose_evt = 1'b0;
      win_evt  = 1'b0;
      @(posedge clk);
      #1;
      cmp("lose_overlay0", 32'(vga0), 32'hF00);
      cmp("lose_overlay1", 32'(vga1), 32'hF00);
      @(negedge clk);
      win_evt = 1'b1;
      @(negedge clk);
      win_evt = 1'b0;
      cmp("lose_sticky", 32'(gs0), 32'd1);
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk);
      #1;
      cmp("restart_state", 32'(gs0), 32'd0);
      cmp("restart_same_edge", 32'(vga0), 32'hF00);
      @(negedge clk);
      restart = 1'b0;
      @(posedge clk);
      #1 cmp("scene_resume", 32'(vga0), 32'h69C);

      // WIN with flashing on the FLASH_FRAMES=2 instance.
      @(negedge clk);
      win_evt = 1'b1;
      @(negedge clk);
      win_evt = 1'b0;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         cmp($sformatf("flash%0d", j), 32'(vga1), flash_exp[j] ? 32'h0F0 : 32'h69C);
         cmp($sformatf("solid%0d", j), 32'(vga0), 32'h0F0);
         frame_start = 1'b1;
         @(negedge clk);
         frame_start = 1'b0;
         repeat (3) @(negedge clk);
      end
      pulse_restart();

      // A frame_start coinciding with entry is not counted.
      @(negedge clk);
      lose_evt = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      lose_evt = 1'b0;
      frame_start = 1'b0;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
      cmp("entry_fs_ignored", 32'(vga1), 32'hF00);
      pulse_restart();

      // 32 layers, 24-bit colour.
      @(negedge clk);
      bright = 1'b1;
      layer_en32 = 32'h8000_0000;
      layer_rgb32[31*24 +: 24] = 24'hABCDEF;
      @(posedge clk);
      @(posedge clk);
      #1;
      cmp("wide_vga", 32'(vga2), 32'hABCDEF);
      cmp("wide_idx", 32'(hl2), 32'd31);
      cmp("wide_hit", 32'(hv2), 32'd1);
      @(negedge clk);
      layer_en32 = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      cmp("wide_bg", 32'(vga2), 32'h00069C);
      cmp("wide_nohit", 32'(hv2), 32'd0);

      // Randomised traffic against the model.
      repeat (3000) begin
         @(negedge clk);
         bright      = ($urandom_range(0, 9) != 0);
         layer_en    = 11'($urandom & $urandom & $urandom);
         layer_rgb   = 132'({$urandom, $urandom, $urandom, $urandom, $urandom});
         layer_en32  = $urandom & $urandom;
         for (int w = 0; w < 24; w++) layer_rgb32[w*32 +: 32] = $urandom;
         lose_evt    = ($urandom_range(0, 99) == 0);
         win_evt     = ($urandom_range(0, 99) == 0);
         restart     = ($urandom_range(0, 399) == 0);
         frame_start = ($urandom_range(0, 5) == 0);
      end
      @(negedge clk);
      lose_evt = 1'b0;
      win_evt = 1'b0;
      restart = 1'b0;
      frame_start = 1'b0;
      repeat (4) @(negedge clk);
      check_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
